// File: rtl/pwm_cfg_sequencer.sv
// pwm_cfg_sequencer: prescaled period counter with double-buffered PWM configuration applied at period wrap
module pwm_cfg_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        cfg_wr,
  input  logic [15:0] cfg_period,
  input  logic [15:0] cfg_compare1,
  input  logic [15:0] cfg_compare2,
  input  logic [7:0]  cfg_functions,
  input  logic [7:0]  cfg_prescale,
  output logic        pwm_en,
  output logic [15:0] period,
  output logic [15:0] compare1,
  output logic [15:0] compare2,
  output logic [7:0]  functions,
  output logic [15:0] count_val,
  output logic        period_end,
  output logic        cfg_pending,
  output logic        cfg_ack
);
  typedef enum logic {IDLE, RUN} state_t;
  typedef struct packed {
    logic [15:0] period;
    logic [15:0] compare1;
    logic [15:0] compare2;
    logic [7:0]  functions;
    logic [7:0]  prescale;
  } cfg_t;
  state_t state, state_nx;
  cfg_t shadow, active, cfg_in;
  logic [7:0] pre_cnt;
  logic tick, wrap;
  assign cfg_in = {cfg_period, cfg_compare1, cfg_compare2, cfg_functions, cfg_prescale};
  assign tick = pre_cnt == active.prescale;
  assign wrap = tick && count_val >= active.period;
  assign pwm_en = state == RUN;
  assign period = active.period;
  assign compare1 = active.compare1;
  assign compare2 = active.compare2;
  assign functions = active.functions;
  always_comb begin
    state_nx = state;
    state_nx = en ? RUN : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
      pre_cnt <= '0;
      count_val <= '0;
      period_end <= 1'b0;
      cfg_pending <= 1'b0;
      cfg_ack <= 1'b0;
    end else begin
      period_end <= 1'b0;
      cfg_ack <= 1'b0;
      if (state == IDLE || !en) begin
        pre_cnt <= '0;
        count_val <= '0;
        cfg_pending <= 1'b0;
        if (cfg_wr) begin
          shadow <= cfg_in;
          active <= cfg_in;
          cfg_ack <= 1'b1;
        end else if (cfg_pending) begin
          active <= shadow;
          cfg_ack <= 1'b1;
        end
      end else begin
        pre_cnt <= tick ? '0 : pre_cnt + 8'd1;
        if (tick) count_val <= wrap ? '0 : count_val + 16'd1;
        period_end <= wrap;
        if (cfg_wr) shadow <= cfg_in;
        cfg_pending <= cfg_wr || (cfg_pending && !wrap);
        if (wrap && cfg_pending) begin
          active <= shadow;
          cfg_ack <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// tb_pwm_cfg_sequencer: directed checks of counting, prescale, deferred config apply and reset
module tb_pwm_cfg_sequencer;
  logic clk = 0, rst_n = 0, en = 0, cfg_wr = 0;
  logic [15:0] cfg_period = 0, cfg_compare1 = 0, cfg_compare2 = 0;
  logic [7:0] cfg_functions = 0, cfg_prescale = 0;
  logic pwm_en, period_end, cfg_pending, cfg_ack;
  logic [15:0] period, compare1, compare2, count_val;
  logic [7:0] functions;
  int n_cmp = 0, n_bad = 0;
  pwm_cfg_sequencer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_wr(cfg_wr),
    .cfg_period(cfg_period), .cfg_compare1(cfg_compare1), .cfg_compare2(cfg_compare2),
    .cfg_functions(cfg_functions), .cfg_prescale(cfg_prescale),
    .pwm_en(pwm_en), .period(period), .compare1(compare1), .compare2(compare2),
    .functions(functions), .count_val(count_val), .period_end(period_end),
    .cfg_pending(cfg_pending), .cfg_ack(cfg_ack)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cfg_wr = 0;
  endtask
  task automatic wr(input logic [15:0] p, input logic [15:0] c1, input logic [15:0] c2,
                    input logic [7:0] f, input logic [7:0] ps);
    cfg_period = p; cfg_compare1 = c1; cfg_compare2 = c2; cfg_functions = f; cfg_prescale = ps;
    cfg_wr = 1;
  endtask
  initial begin
    logic [15:0] exp_cnt [6];
    logic exp_pe [6];
    exp_cnt = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd0};
    exp_pe = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    check("rst_pwm_en", pwm_en, 0);
    check("rst_count", count_val, 0);
    check("rst_period", period, 0);
    check("rst_pending", cfg_pending, 0);
    check("rst_ack", cfg_ack, 0);
    check("rst_period_end", period_end, 0);
    rst_n = 1;
    step();
    wr(16'd3, 16'd2, 16'd1, 8'h02, 8'd0);
    step();
    check("idle_wr_period", period, 3);
    check("idle_wr_cmp1", compare1, 2);
    check("idle_wr_func", functions, 8'h02);
    check("idle_wr_ack", cfg_ack, 1);
    check("idle_wr_pending", cfg_pending, 0);
    step();
    check("idle_ack_clear", cfg_ack, 0);
    en = 1;
    step();
    check("run_pwm_en", pwm_en, 1);
    check("run_entry_count", count_val, 0);
    check("run_entry_pe", period_end, 0);
    for (int i = 0; i < 9; i++) begin
      step();
      check("p3_count", count_val, 32'((i + 1) % 4));
      check("p3_period_end", period_end, 32'((i + 1) % 4 == 0));
    end
    wr(16'd1, 16'd1, 16'd1, 8'h01, 8'd2);
    step();
    check("run_wr_pending", cfg_pending, 1);
    check("run_wr_period_held", period, 3);
    check("run_wr_no_ack", cfg_ack, 0);
    step();
    step();
    check("ps_apply_count", count_val, 0);
    check("ps_apply_period", period, 1);
    check("ps_apply_ack", cfg_ack, 1);
    check("ps_apply_pe", period_end, 1);
    check("ps_apply_pending", cfg_pending, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("ps2_count", count_val, exp_cnt[i]);
      check("ps2_period_end", period_end, exp_pe[i]);
    end
    wr(16'd9, 16'd3, 16'd1, 8'h01, 8'd0);
    step();
    repeat (5) step();
    check("p9_apply_count", count_val, 0);
    check("p9_apply_period", period, 9);
    check("p9_apply_ack", cfg_ack, 1);
    check("p9_apply_pe", period_end, 1);
    repeat (3) step();
    check("p9_count3", count_val, 3);
    wr(16'd4, 16'd2, 16'd1, 8'h01, 8'd0);
    step();
    check("defer_count", count_val, 4);
    check("defer_period_held", period, 9);
    check("defer_cmp1_held", compare1, 3);
    check("defer_pending", cfg_pending, 1);
    repeat (5) step();
    check("defer_count9", count_val, 9);
    check("defer_no_ack", cfg_ack, 0);
    check("defer_period9", period, 9);
    step();
    check("defer_wrap_count", count_val, 0);
    check("defer_wrap_period", period, 4);
    check("defer_wrap_cmp1", compare1, 2);
    check("defer_wrap_ack", cfg_ack, 1);
    check("defer_wrap_pe", period_end, 1);
    wr(16'd4, 16'd5, 16'd1, 8'h01, 8'd0);
    step();
    wr(16'd4, 16'd7, 16'd1, 8'h01, 8'd0);
    step();
    step();
    step();
    check("multi_count4", count_val, 4);
    check("multi_cmp1_held", compare1, 2);
    wr(16'd4, 16'd9, 16'd1, 8'h01, 8'd0);
    step();
    check("multi_wrap_count", count_val, 0);
    check("multi_wrap_cmp1", compare1, 7);
    check("multi_wrap_ack", cfg_ack, 1);
    check("multi_wrap_pending", cfg_pending, 1);
    step();
    check("multi_single_ack", cfg_ack, 0);
    check("multi_still_pending", cfg_pending, 1);
    check("multi_cmp1_7", compare1, 7);
    repeat (4) step();
    check("third_wrap_count", count_val, 0);
    check("third_wrap_cmp1", compare1, 9);
    check("third_wrap_ack", cfg_ack, 1);
    check("third_wrap_pending", cfg_pending, 0);
    wr(16'd0, 16'd9, 16'd4, 8'h01, 8'd0);
    step();
    check("drop_pre_pending", cfg_pending, 1);
    en = 0;
    step();
    check("drop_pwm_en", pwm_en, 0);
    check("drop_count", count_val, 0);
    check("drop_ack", cfg_ack, 1);
    check("drop_period", period, 0);
    check("drop_cmp2", compare2, 4);
    check("drop_pending", cfg_pending, 0);
    en = 1;
    step();
    check("p0_entry_pe", period_end, 0);
    step();
    check("p0_tick1_pe", period_end, 1);
    check("p0_tick1_count", count_val, 0);
    step();
    check("p0_tick2_pe", period_end, 1);
    wr(16'd7, 16'd3, 16'd3, 8'h03, 8'd0);
    step();
    check("rst_pre_pending", cfg_pending, 1);
    #1 rst_n = 0;
    #1;
    check("async_pwm_en", pwm_en, 0);
    check("async_period", period, 0);
    check("async_cmp1", compare1, 0);
    check("async_pending", cfg_pending, 0);
    check("async_count", count_val, 0);
    check("async_func", functions, 0);
    en = 0;
    @(negedge clk);
    rst_n = 1;
    step();
    check("post_rst_pwm_en", pwm_en, 0);
    check("post_rst_pending", cfg_pending, 0);
    check("post_rst_period", period, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
